// File: rtl/icb_csr_sram_bridge.sv
// ICB slave bridge: byte-maskable CSR bank plus a word window onto accelerator SRAM.
module icb_csr_sram_bridge #(
  parameter int unsigned NUM_CSR     = 4,
  parameter int unsigned SRAM_AW     = 13,
  parameter int unsigned SRAM_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      icb_cmd_valid,
  output logic                      icb_cmd_ready,
  input  logic                      icb_cmd_read,
  input  logic [31:0]               icb_cmd_addr,
  input  logic [31:0]               icb_cmd_wdata,
  input  logic [3:0]                icb_cmd_wmask,
  output logic                      icb_rsp_valid,
  input  logic                      icb_rsp_ready,
  output logic [31:0]               icb_rsp_rdata,
  output logic                      icb_rsp_err,
  output logic [7:0]                ctrl_mode_o,
  output logic                      start_o,
  output logic [(NUM_CSR-2)*32-1:0] param_o,
  input  logic                      busy_i,
  input  logic                      done_i,
  output logic                      irq_o,
  output logic                      sram_wr_en,
  output logic [SRAM_AW-1:0]        sram_wr_addr,
  output logic [31:0]               sram_wr_data,
  output logic [3:0]                sram_wr_be,
  output logic                      sram_rd_en,
  output logic [SRAM_AW-1:0]        sram_rd_addr,
  input  logic [31:0]               sram_rd_data
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, SRD, RSP} state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q;
  logic                 irq_en_q;
  logic                 done_sticky_q;
  logic                 accept_c;
  logic                 sel_sram_c;
  logic                 csr_hit_c;
  logic                 rd_done_c;
  logic [SRAM_AW-1:0]   word_c;
  logic [NUM_CSR-1:0]   csr_wr_c;
  logic [31:0]          csr_rd_c;
  logic                 unused_addr_bits;

  // Address decode: the window bit picks SRAM, otherwise a low word index picks a CSR.
  assign word_c           = icb_cmd_addr[SRAM_AW+1:2];
  assign sel_sram_c       = icb_cmd_addr[SRAM_AW+2];
  assign csr_hit_c        = !sel_sram_c && (word_c < SRAM_AW'(NUM_CSR));
  assign accept_c         = icb_cmd_valid && icb_cmd_ready;
  assign unused_addr_bits = ^{icb_cmd_addr[31:SRAM_AW+3], icb_cmd_addr[1:0]};

  // Per-CSR write strobes and read-back mux.
  always_comb begin
    csr_wr_c = '0;
    csr_rd_c = '0;
    for (int i = 0; i < int'(NUM_CSR); i++) begin
      csr_wr_c[i] = accept_c && !icb_cmd_read && csr_hit_c && (word_c == SRAM_AW'(i));
    end
    if (word_c == SRAM_AW'(0)) begin
      csr_rd_c = {16'h0, ctrl_mode_o, 6'h0, irq_en_q, 1'b0};
    end else if (word_c == SRAM_AW'(1)) begin
      csr_rd_c = {30'h0, done_sticky_q, busy_i};
    end else begin
      for (int i = 2; i < int'(NUM_CSR); i++) begin
        if (word_c == SRAM_AW'(i)) csr_rd_c = param_o[(i-2)*32 +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic: one outstanding command, SRAM reads wait out the array latency.
  always_comb begin
    state_n   = state_q;
    rd_done_c = 1'b0;
    unique case (state_q)
      IDLE: if (accept_c) state_n = (icb_cmd_read && sel_sram_c) ? SRD : RSP;
      SRD: begin
        if (cnt_q == CW'(SRAM_RD_LAT)) begin
          rd_done_c = 1'b1;
          state_n   = RSP;
        end
      end
      RSP:     if (icb_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags, latency counter and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_cmd_ready <= 1'b0;
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= '0;
      icb_rsp_err   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      icb_cmd_ready <= (state_n == IDLE);
      icb_rsp_valid <= (state_n == RSP);
      if (state_q == SRD) cnt_q <= cnt_q + CW'(1);
      if (accept_c) begin
        cnt_q         <= '0;
        icb_rsp_err   <= !sel_sram_c && !csr_hit_c;
        icb_rsp_rdata <= (icb_cmd_read && csr_hit_c) ? csr_rd_c : '0;
      end else if (rd_done_c) begin
        icb_rsp_rdata <= sram_rd_data;
      end else if ((state_q == RSP) && icb_rsp_ready) begin
        icb_rsp_rdata <= '0;
        icb_rsp_err   <= 1'b0;
      end
    end
  end

  // CSR bank: control, sticky done status, interrupt and parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_mode_o   <= '0;
      irq_en_q      <= 1'b0;
      done_sticky_q <= 1'b0;
      start_o       <= 1'b0;
      irq_o         <= 1'b0;
      param_o       <= '0;
    end else begin
      start_o <= csr_wr_c[0] && icb_cmd_wmask[0] && icb_cmd_wdata[0] && !busy_i;
      irq_o   <= done_sticky_q && irq_en_q;
      if (done_i) begin
        done_sticky_q <= 1'b1;
      end else if (csr_wr_c[1] && icb_cmd_wmask[0] && icb_cmd_wdata[1]) begin
        done_sticky_q <= 1'b0;
      end
      if (csr_wr_c[0]) begin
        if (icb_cmd_wmask[0]) irq_en_q    <= icb_cmd_wdata[1];
        if (icb_cmd_wmask[1]) ctrl_mode_o <= icb_cmd_wdata[15:8];
      end
      for (int i = 2; i < int'(NUM_CSR); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (csr_wr_c[i] && icb_cmd_wmask[b]) begin
            param_o[(i-2)*32 + b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // SRAM strobes: one-cycle pulses with the command's address and data registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wr_en   <= 1'b0;
      sram_wr_addr <= '0;
      sram_wr_data <= '0;
      sram_wr_be   <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
    end else begin
      sram_wr_en <= accept_c && sel_sram_c && !icb_cmd_read;
      sram_rd_en <= accept_c && sel_sram_c && icb_cmd_read;
      if (accept_c && sel_sram_c) begin
        if (icb_cmd_read) begin
          sram_rd_addr <= word_c;
        end else begin
          sram_wr_addr <= word_c;
          sram_wr_data <= icb_cmd_wdata;
          sram_wr_be   <= icb_cmd_wmask;
        end
      end
    end
  end

endmodule

// File: tb/tb_icb_csr_sram_bridge.sv
// Self-checking bench for icb_csr_sram_bridge with a latency-2 SRAM model.
module tb_icb_csr_sram_bridge;

  localparam int NUM_CSR = 4;
  localparam int AW      = 13;
  localparam int LAT     = 2;
  localparam int NP      = NUM_CSR - 2;

  logic                clk;
  logic                rst_n;
  logic                icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0]         icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]          icb_cmd_wmask;
  logic                icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0]         icb_rsp_rdata;
  logic [7:0]          ctrl_mode_o;
  logic                start_o, busy_i, done_i, irq_o;
  logic [NP*32-1:0]    param_o;
  logic                sram_wr_en, sram_rd_en;
  logic [AW-1:0]       sram_wr_addr, sram_rd_addr;
  logic [31:0]         sram_wr_data, sram_rd_data;
  logic [3:0]          sram_wr_be;

  icb_csr_sram_bridge #(.NUM_CSR(NUM_CSR), .SRAM_AW(AW), .SRAM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .ctrl_mode_o(ctrl_mode_o), .start_o(start_o), .param_o(param_o),
    .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_be(sram_wr_be), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: byte-enabled writes, reads return after LAT cycles, junk otherwise.
  logic [31:0] mem [int];
  logic [31:0] rd_pipe [LAT];
  logic [31:0] wtmp;
  int          wk;
  always @(posedge clk) begin
    if (sram_wr_en) begin
      wk   = int'(sram_wr_addr);
      wtmp = mem.exists(wk) ? mem[wk] : 32'h0;
      for (int b = 0; b < 4; b++) if (sram_wr_be[b]) wtmp[b*8 +: 8] = sram_wr_data[b*8 +: 8];
      mem[wk] = wtmp;
    end
    rd_pipe[0] <= (sram_rd_en && mem.exists(int'(sram_rd_addr))) ? mem[int'(sram_rd_addr)] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rd_data = rd_pipe[LAT-1];

  // Reference model state.
  logic [31:0] ref_mem [int];
  logic [31:0] m_param [NP];
  logic [7:0]  m_mode;
  logic        m_irq_en, m_done;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations.
  logic [31:0]   t_rdata;
  logic          t_err;
  int            t_lat, t_wr_n, t_rd_n, t_rd_cyc, t_st_n;
  logic [AW-1:0] last_wr_addr;
  logic [31:0]   last_wr_data;
  logic [3:0]    last_wr_be;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sram_addr(input int w);
    logic [31:0] a;
    a       = $urandom;
    a[15]   = 1'b1;
    a[14:2] = 13'(w);
    return a;
  endfunction

  function automatic logic [31:0] csr_addr(input int k);
    logic [31:0] a;
    a       = $urandom;
    a[15]   = 1'b0;
    a[14:2] = 13'(k);
    return a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Issue one command, observe strobes and response latency, then complete the handshake.
  task automatic icb_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] wm, input logic done_acc);
    int n;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    if (done_acc) done_i = 1'b1;
    n = 0;
    while (!icb_cmd_ready && n < 50) begin tick(); n++; end
    checks++;
    if (icb_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_timeout got=%b exp=1", icb_cmd_ready);
    end
    tick();
    icb_cmd_valid = 1'b0;
    done_i        = 1'b0;
    t_lat = 1; t_wr_n = 0; t_rd_n = 0; t_rd_cyc = 0; t_st_n = 0;
    while (1) begin
      if (sram_wr_en) begin
        t_wr_n++;
        last_wr_addr = sram_wr_addr;
        last_wr_data = sram_wr_data;
        last_wr_be   = sram_wr_be;
      end
      if (sram_rd_en) begin t_rd_n++; t_rd_cyc = t_lat; end
      if (start_o) t_st_n++;
      if (icb_rsp_valid || t_lat >= 20) break;
      tick();
      t_lat++;
    end
    checks++;
    if (icb_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid_timeout got=%b exp=1", icb_rsp_valid);
    end
    t_rdata = icb_rsp_rdata;
    t_err   = icb_rsp_err;
    tick();
  endtask

  task automatic test_reset();
    logic any;
    rst_n = 1'b0; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b1; busy_i = 1'b0; done_i = 1'b0;
    m_mode = '0; m_irq_en = 1'b0; m_done = 1'b0;
    for (int i = 0; i < NP; i++) m_param[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    any = |{icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, ctrl_mode_o, start_o, param_o,
            irq_o, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_be, sram_rd_en, sram_rd_addr};
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", any); end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", icb_cmd_ready); end
  endtask

  task automatic test_param();
    logic [31:0] wd;
    logic [3:0]  wm;
    int          k;
    icb_txn(1'b0, 32'h0000_0008, 32'hA5A5_1234, 4'b0101, 1'b0);
    m_param[0] = merge(m_param[0], 32'hA5A5_1234, 4'b0101);
    icb_txn(1'b1, 32'h0000_0008, 32'h0, 4'h0, 1'b0);
    checks++;
    if ({t_rdata, t_err, 8'(t_lat)} !== {32'h00A5_0034, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL param_masked rdata=%h err=%b lat=%0d exp=00a50034/0/1", t_rdata, t_err, t_lat);
    end
    for (int it = 0; it < 24; it++) begin
      k = 2 + int'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom; wm = 4'($urandom);
        icb_txn(1'b0, csr_addr(k), wd, wm, 1'b0);
        m_param[k-2] = merge(m_param[k-2], wd, wm);
        checks++;
        if ({t_err, 8'(t_lat)} !== {1'b0, 8'd1}) begin
          errors++; $display("FAIL param_wr_rsp err=%b lat=%0d exp=0/1", t_err, t_lat);
        end
      end else begin
        icb_txn(1'b1, csr_addr(k), 32'h0, 4'h0, 1'b0);
        checks++;
        if (t_rdata !== m_param[k-2]) begin
          errors++; $display("FAIL param_rd csr%0d got=%h exp=%h", k, t_rdata, m_param[k-2]);
        end
      end
    end
    checks++;
    if (param_o !== {m_param[1], m_param[0]}) begin
      errors++; $display("FAIL param_o got=%h exp=%h", param_o, {m_param[1], m_param[0]});
    end
  endtask

  task automatic test_sram();
    int          words [8];
    int          w;
    logic [31:0] wd;
    logic [3:0]  wm;
    icb_txn(1'b0, 32'h0000_8014, 32'hDEAD_BEEF, 4'hF, 1'b0);
    ref_mem[5] = 32'hDEAD_BEEF;
    checks++;
    if ({8'(t_wr_n), last_wr_addr, last_wr_be, last_wr_data} !== {8'd1, 13'd5, 4'hF, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sram_wr_strobe n=%0d addr=%0d be=%h data=%h exp=1/5/f/deadbeef",
               t_wr_n, last_wr_addr, last_wr_be, last_wr_data);
    end
    icb_txn(1'b1, 32'h0000_8014, 32'h0, 4'h0, 1'b0);
    checks++;
    if ({8'(t_rd_n), 8'(t_rd_cyc), 8'(t_lat)} !== {8'd1, 8'd1, 8'd4}) begin
      errors++; $display("FAIL sram_rd_timing n=%0d en_cyc=%0d lat=%0d exp=1/1/4", t_rd_n, t_rd_cyc, t_lat);
    end
    checks++;
    if ({t_rdata, t_err} !== {32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL sram_rd_data got=%h err=%b exp=deadbeef/0", t_rdata, t_err);
    end
    for (int i = 0; i < 8; i++) begin
      words[i] = int'($urandom_range(0, 8191));
      wd = $urandom;
      icb_txn(1'b0, sram_addr(words[i]), wd, 4'hF, 1'b0);
      ref_mem[words[i]] = wd;
    end
    for (int it = 0; it < 24; it++) begin
      w = words[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom; wm = 4'($urandom);
        icb_txn(1'b0, sram_addr(w), wd, wm, 1'b0);
        ref_mem[w] = merge(ref_mem[w], wd, wm);
        checks++;
        if ({8'(t_wr_n), last_wr_addr, last_wr_be, t_err} !== {8'd1, 13'(w), wm, 1'b0}) begin
          errors++; $display("FAIL sram_wr_rand n=%0d addr=%0d be=%h err=%b exp=1/%0d/%h/0",
                              t_wr_n, last_wr_addr, last_wr_be, t_err, w, wm);
        end
      end else begin
        icb_txn(1'b1, sram_addr(w), 32'h0, 4'h0, 1'b0);
        checks++;
        if ({t_rdata, 8'(t_lat)} !== {ref_mem[w], 8'd4}) begin
          errors++; $display("FAIL sram_rd_rand word=%0d got=%h lat=%0d exp=%h/4", w, t_rdata, t_lat, ref_mem[w]);
        end
      end
    end
  endtask

  task automatic test_decode_err();
    logic [31:0] a;
    icb_txn(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    checks++;
    if ({t_err, t_rdata, 8'(t_lat)} !== {1'b1, 32'h0, 8'd1}) begin
      errors++; $display("FAIL err_rd err=%b rdata=%h lat=%0d exp=1/0/1", t_err, t_rdata, t_lat);
    end
    icb_txn(1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 1'b0);
    checks++;
    if ({t_err, 8'(t_wr_n), param_o} !== {1'b1, 8'd0, m_param[1], m_param[0]}) begin
      errors++; $display("FAIL err_wr err=%b wr_n=%0d param=%h", t_err, t_wr_n, param_o);
    end
    for (int it = 0; it < 6; it++) begin
      a = csr_addr(int'($urandom_range(NUM_CSR, 8191)));
      icb_txn(1'(it % 2), a, $urandom, 4'hF, 1'b0);
      checks++;
      if ({t_err, t_rdata, 8'(t_wr_n + t_rd_n + t_st_n)} !== {1'b1, 32'h0, 8'd0}) begin
        errors++; $display("FAIL err_rand addr=%h err=%b rdata=%h side=%0d", a, t_err, t_rdata, t_wr_n + t_rd_n + t_st_n);
      end
    end
    checks++;
    if (param_o !== {m_param[1], m_param[0]}) begin
      errors++; $display("FAIL err_param_kept got=%h exp=%h", param_o, {m_param[1], m_param[0]});
    end
  endtask

  task automatic test_ctrl();
    busy_i = 1'b0;
    icb_txn(1'b0, 32'h0000_0000, 32'h0000_0103, 4'hF, 1'b0);
    m_mode = 8'h01; m_irq_en = 1'b1;
    checks++;
    if ({8'(t_st_n), start_o, ctrl_mode_o} !== {8'd1, 1'b0, m_mode}) begin
      errors++; $display("FAIL start_pulse n=%0d start_now=%b mode=%h exp=1/0/%h", t_st_n, start_o, ctrl_mode_o, m_mode);
    end
    icb_txn(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
    checks++;
    if (t_rdata !== {16'h0, m_mode, 6'h0, m_irq_en, 1'b0}) begin
      errors++; $display("FAIL ctrl_rd got=%h exp=00000102", t_rdata);
    end
    busy_i = 1'b1;
    icb_txn(1'b0, 32'h0000_0000, 32'h0000_0103, 4'hF, 1'b0);
    checks++;
    if ({8'(t_st_n), t_err} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL start_busy n=%0d err=%b exp=0/0", t_st_n, t_err);
    end
    busy_i = 1'b0;
    icb_txn(1'b0, 32'h0000_0000, 32'h0000_0101, 4'b1110, 1'b0);
    checks++;
    if ({8'(t_st_n), ctrl_mode_o} !== {8'd0, m_mode}) begin
      errors++; $display("FAIL start_unmasked n=%0d mode=%h exp=0/%h", t_st_n, ctrl_mode_o, m_mode);
    end
  endtask

  task automatic test_status();
    done_i = 1'b1; tick(); done_i = 1'b0;
    m_done = 1'b1;
    tick(); tick();
    checks++;
    if (irq_o !== (m_done & m_irq_en)) begin errors++; $display("FAIL irq_set got=%b exp=1", irq_o); end
    icb_txn(1'b1, 32'h0000_0004, 32'h0, 4'h0, 1'b0);
    checks++;
    if (t_rdata !== {30'h0, m_done, busy_i}) begin errors++; $display("FAIL status_done got=%h exp=2", t_rdata); end
    icb_txn(1'b0, 32'h0000_0004, 32'h0000_0002, 4'h1, 1'b1);
    icb_txn(1'b1, 32'h0000_0004, 32'h0, 4'h0, 1'b0);
    checks++;
    if (t_rdata !== {30'h0, m_done, busy_i}) begin errors++; $display("FAIL status_set_wins got=%h exp=2", t_rdata); end
    icb_txn(1'b0, 32'h0000_0004, 32'h0000_0002, 4'h1, 1'b0);
    m_done = 1'b0;
    busy_i = 1'b1;
    icb_txn(1'b1, 32'h0000_0004, 32'h0, 4'h0, 1'b0);
    checks++;
    if (t_rdata !== {30'h0, m_done, busy_i}) begin errors++; $display("FAIL status_w1c got=%h exp=1", t_rdata); end
    busy_i = 1'b0;
    tick();
    checks++;
    if (irq_o !== (m_done & m_irq_en)) begin errors++; $display("FAIL irq_clr got=%b exp=0", irq_o); end
  endtask

  task automatic test_backpressure();
    int n;
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = csr_addr(3); icb_cmd_wmask = 4'h0;
    n = 0;
    while (!icb_cmd_ready && n < 50) begin tick(); n++; end
    tick();
    icb_cmd_valid = 1'b0;
    n = 0;
    while (!icb_rsp_valid && n < 20) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({icb_rsp_valid, icb_cmd_ready, icb_rsp_err, icb_rsp_rdata} !== {1'b1, 1'b0, 1'b0, m_param[1]}) begin
        errors++; $display("FAIL rsp_hold c=%0d v=%b rdy=%b err=%b rdata=%h exp=1/0/0/%h",
                            c, icb_rsp_valid, icb_cmd_ready, icb_rsp_err, icb_rsp_rdata, m_param[1]);
      end
    end
    icb_rsp_ready = 1'b1;
    tick();
    checks++;
    if ({icb_rsp_valid, icb_rsp_rdata} !== 33'h0) begin
      errors++; $display("FAIL rsp_release v=%b rdata=%h exp=0/0", icb_rsp_valid, icb_rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic any;
    int   n;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h0000_8014;
    n = 0;
    while (!icb_cmd_ready && n < 50) begin tick(); n++; end
    tick();
    icb_cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    any = |{icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, ctrl_mode_o, start_o, param_o,
            irq_o, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_be, sram_rd_en, sram_rd_addr};
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL reset_mid_outputs got=%b exp=0", any); end
    tick(); tick();
    rst_n = 1'b1;
    m_mode = '0; m_irq_en = 1'b0; m_done = 1'b0;
    for (int i = 0; i < NP; i++) m_param[i] = '0;
    any = 1'b0;
    for (int c = 0; c < 6; c++) begin tick(); any = any | icb_rsp_valid; end
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL reset_drops_rsp got=%b exp=0", any); end
    icb_txn(1'b1, csr_addr(2), 32'h0, 4'h0, 1'b0);
    checks++;
    if ({t_rdata, t_err, 8'(t_lat)} !== {m_param[0], 1'b0, 8'd1}) begin
      errors++; $display("FAIL post_reset_csr rdata=%h err=%b lat=%0d exp=0/0/1", t_rdata, t_err, t_lat);
    end
    icb_txn(1'b1, 32'h0000_8014, 32'h0, 4'h0, 1'b0);
    checks++;
    if ({t_rdata, 8'(t_lat)} !== {ref_mem[5], 8'd4}) begin
      errors++; $display("FAIL post_reset_sram rdata=%h lat=%0d exp=%h/4", t_rdata, t_lat, ref_mem[5]);
    end
  endtask

  initial begin
    test_reset();
    test_param();
    test_sram();
    test_decode_err();
    test_ctrl();
    test_status();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icb_csr_sram_bridge.md
Name: icb_csr_sram_bridge

Overview:
Parametrised ICB slave that fronts an accelerator. It provides a byte-maskable CSR bank (control, sticky status/interrupt, N parameter registers) and a word window onto the accelerator SRAM with configurable read latency. It tracks one outstanding command through an explicit FSM and returns an error response on unmapped addresses. It sits between the E203 ICB fabric and the accelerator core/SRAM.

Parameters:
NUM_CSR, 4, number of 32-bit CSRs (>=3): CSR0 CTRL, CSR1 STATUS, CSR2..NUM_CSR-1 PARAM.
SRAM_AW, 13, SRAM word-address width.
SRAM_RD_LAT, 1, SRAM read latency in cycles from sram_rd_en to valid sram_rd_data (1..3).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_read  in  1  1=read, 0=write
icb_cmd_addr  in  32  byte address
icb_cmd_wdata  in  32  write data
icb_cmd_wmask  in  4  byte enables, 1=write byte
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_rdata  out  32  read data
icb_rsp_err  out  1  decode error
ctrl_mode_o  out  8  CTRL[15:8]
start_o  out  1  one-cycle start pulse
param_o  out  (NUM_CSR-2)*32  PARAM regs, CSR2 in LSBs
busy_i  in  1  accelerator busy
done_i  in  1  accelerator done pulse
irq_o  out  1  interrupt
sram_wr_en  out  1  SRAM write strobe
sram_wr_addr  out  SRAM_AW  SRAM write word address
sram_wr_data  out  32  SRAM write data
sram_wr_be  out  4  SRAM byte enables
sram_rd_en  out  1  SRAM read strobe
sram_rd_addr  out  SRAM_AW  SRAM read word address
sram_rd_data  in  32  SRAM read data

Behaviour:
- Reset: all outputs 0, all CSRs 0, FSM IDLE. Reset mid-transaction drops the pending response.
- Decode (bits above SRAM_AW+2 ignored): addr[SRAM_AW+2]=1 selects SRAM, word = addr[SRAM_AW+1:2]. addr[SRAM_AW+2]=0 and addr[SRAM_AW+1:2]<NUM_CSR selects that CSR. All other addresses are errors. addr[1:0] are ignored.
- FSM states: IDLE, SRD (SRAM read wait), RSP. icb_cmd_ready = (state==IDLE). Accept = valid & ready.
- Write accept: IDLE->RSP. icb_rsp_valid rises the next cycle.
  - SRAM target: sram_wr_en pulses 1 cycle (the cycle after accept) with registered addr, data and be = wmask.
  - CSR target: updates take effect the cycle after accept; only masked bytes change.
- Read accept, CSR target: rdata captured at accept; IDLE->RSP. Latency 1 cycle.
- Read accept, SRAM target: sram_rd_en pulses 1 cycle (the cycle after accept) with registered address. FSM enters SRD and counts SRAM_RD_LAT cycles, then captures sram_rd_data and enters RSP. rsp_valid rises 1+SRAM_RD_LAT+1 cycles after accept.
- Error (either direction): no side effects, rsp_err=1, rdata=0, latency 1.
- RSP holds rsp_valid, rdata and err stable until rsp_ready=1, then goes to IDLE. err and rdata return to 0 when the response is not valid.
- CTRL (CSR0): bit0 START is write-1; reads 0. bit1 IRQ_EN is RW. bits[15:8] MODE are RW. Other bits read 0.
  - start_o pulses 1 cycle when START is written with wmask[0]=1 and busy_i=0.
  - A START write while busy_i=1 is ignored, with no error.
- STATUS (CSR1): read value = {30'b0, done_sticky, busy_i}.
  - done_sticky sets on done_i=1.
  - Writing 1 to bit1 with wmask[0]=1 clears done_sticky. If done_i arrives in the same cycle, set wins.
- PARAM (CSR2..): full 32-bit RW, byte-masked, exported on param_o.
- irq_o = done_sticky & IRQ_EN, registered.

Test Plan:
- Write CSR2 0xA5A5_1234 with wmask=4'b0101, then read it -> reads 0x00A5_0034; read rsp_valid 1 cycle after accept, err=0.
- SRAM_RD_LAT=2: write SRAM word 5 (addr 0x8014) 0xDEADBEEF, wmask 4'hF -> sram_wr_en 1 cycle, sram_wr_addr=5, be=4'hF. Read back -> sram_rd_en 1 cycle after accept, rsp_valid 4 cycles after accept, rdata=0xDEADBEEF.
- NUM_CSR=4: read addr 0x0010 -> err=1, rdata=0. Write there -> err=1, param_o unchanged.
- Write CTRL 0x0000_0103 with busy_i=0 -> start_o 1-cycle pulse, ctrl_mode_o=0x01, CTRL reads 0x102. Repeat with busy_i=1 -> no pulse.
- done_i pulse with IRQ_EN=1 -> STATUS reads 0x2, irq_o=1. W1C write to STATUS in the same cycle as another done_i -> still 0x2. W1C alone -> 0x0, irq_o=0.
- Hold rsp_ready=0 for 5 cycles -> rsp held stable, cmd_ready=0 throughout. Assert rst_n=0 during SRD -> all outputs 0, next command accepted normally.
